cp0_intc: RTL

//  Parametrised second-generation CP0: BadVAddr, Count, Compare, Status, Cause and EPC registers,

---
 rtl/cp0_intc_pkg.sv | 41 ++++
 rtl/cp0_intc_timer.sv | 65 ++++++
 rtl/cp0_intc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cp0_intc_pkg.sv
// cp0_intc_pkg: shared constants for the CP0 slice.
//   - mfc0/mtc0 register addresses, encoded as {rd[4:0], sel[2:0]}
//   - exception codes that the register logic reacts to
//   - bit positions of the Status and Cause fields
//   - exception entry vectors for boot (BEV=1) and normal operation
package cp0_intc_pkg;

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;

    // Status fields
    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned ST_IM_LO  = 8;
    localparam int unsigned ST_BEV    = 22;

    // Cause fields
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_IPHW_LO = 10;
    localparam int unsigned CA_TI     = 30;
    localparam int unsigned CA_BD     = 31;

    localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_intc_timer.sv
// cp0_intc_timer: Count/Compare timer with a programmable tick divider.
//   clk, resetn     clock, synchronous active-low reset
//   i_wen_count     mtc0 to Count: load i_wdata and restart the divider
//   i_wen_compare   mtc0 to Compare: load i_wdata and clear the timer interrupt
//   i_wdata         mtc0 data
//   o_count         Count register
//   o_compare       Compare register (not reset)
//   o_timer_int     sticky timer interrupt, set the cycle after Count==Compare
module cp0_intc_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_wen_count,
    input  logic        i_wen_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    localparam int unsigned TW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(COUNT_DIV - 1);

    logic [TW-1:0] r_tick;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_timer_int;
    logic          w_tick_done;

    assign w_tick_done = (r_tick == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick      <= '0;
            r_count     <= '0;
            r_timer_int <= 1'b0;
        end else begin
            if (i_wen_count) begin
                r_count <= i_wdata;
                r_tick  <= '0;
            end else if (w_tick_done) begin
                r_count <= r_count + 32'd1;
                r_tick  <= '0;
            end else begin
                r_tick  <= r_tick + TW'(1);
            end
            // A Compare write clears the interrupt even if the match fires this cycle.
            if (i_wen_compare)
                r_timer_int <= 1'b0;
            else if (r_count == r_compare)
                r_timer_int <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wen_compare)
            r_compare <= i_wdata;
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) with
// interrupt arbitration and exception entry-vector generation.
//   clk, resetn   clock, synchronous active-low reset
//   ext_int       level external interrupts -> Cause.IP[2+:EXT_INT_W]
//   wen/addr/wdata mtc0 write port; addr = {rd, sel}
//   rdata         mfc0 read data, combinational from addr (0 for unimplemented)
//   ex_valid/ex_excode/ex_bd/ex_epc/ex_badvaddr/ex_eret  committed exception or eret
//   int_req       registered interrupt request to the front end
//   ex_entry      exception vector selected by Status.BEV
//   status/cause/epc  live register values
// Build option: define CP0_EXT_INT_SYNC_EN to pass ext_int through a 2-flop
// synchroniser (adds 2 cycles of interrupt latency).
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter int unsigned EXT_INT_W = 6,
    parameter int unsigned COUNT_DIV = 2,
    parameter int unsigned TIMER_IP  = 7
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 wen,
    input  logic [7:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic                 ex_valid,
    input  logic [4:0]           ex_excode,
    input  logic                 ex_bd,
    input  logic [31:0]          ex_epc,
    input  logic [31:0]          ex_badvaddr,
    input  logic                 ex_eret,
    output logic                 int_req,
    output logic [31:0]          ex_entry,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc
);

    logic [EXT_INT_W-1:0] w_ext_int;

`ifdef CP0_EXT_INT_SYNC_EN
    logic [EXT_INT_W-1:0] r_ext_meta;
    logic [EXT_INT_W-1:0] r_ext_sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ext_meta <= '0;
            r_ext_sync <= '0;
        end else begin
            r_ext_meta <= ext_int;
            r_ext_sync <= r_ext_meta;
        end
    end

    assign w_ext_int = r_ext_sync;
`else
    assign w_ext_int = ext_int;
`endif

    logic        w_wen_count, w_wen_compare, w_wen_status, w_wen_cause, w_wen_epc;
    logic        w_exc, w_eret;
    logic [31:0] w_count, w_compare;
    logic        w_timer_int;
    logic [5:0]  w_hw_ip;

    assign w_wen_count   = wen && (addr == ADDR_COUNT);
    assign w_wen_compare = wen && (addr == ADDR_COMPARE);
    assign w_wen_status  = wen && (addr == ADDR_STATUS);
    assign w_wen_cause   = wen && (addr == ADDR_CAUSE);
    assign w_wen_epc     = wen && (addr == ADDR_EPC);
    assign w_exc         = ex_valid && !ex_eret;
    assign w_eret        = ex_valid && ex_eret;

    cp0_intc_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk           (clk),
        .resetn        (resetn),
        .i_wen_count   (w_wen_count),
        .i_wen_compare (w_wen_compare),
        .i_wdata       (wdata),
        .o_count       (w_count),
        .o_compare     (w_compare),
        .o_timer_int   (w_timer_int)
    );

    // Hardware IP[7:2]: external lines from IP2 upward, timer ORed into its slot.
    assign w_hw_ip = 6'(w_ext_int) | (6'(w_timer_int) << (TIMER_IP - 2));

    logic        r_bev, r_exl, r_ie;
    logic [7:0]  r_im;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic        r_int_req;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    // Exception/eret assignments come last so they override a same-cycle mtc0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bev     <= 1'b1;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip_hw   <= '0;
            r_ip_sw   <= '0;
            r_exccode <= '0;
            r_int_req <= 1'b0;
        end else begin
            r_ip_hw   <= w_hw_ip;
            r_int_req <= ex_valid ? 1'b0
                       : (r_ie && !r_exl && |({r_ip_hw, r_ip_sw} & r_im));
            if (w_wen_status) begin
                r_exl <= wdata[ST_EXL];
                r_ie  <= wdata[ST_IE];
            end
            if (w_wen_cause)
                r_ip_sw <= wdata[CA_IP_LO +: 2];
            if (w_exc) begin
                r_exl     <= 1'b1;
                r_exccode <= ex_excode;
                if (!r_exl)
                    r_bd <= ex_bd;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end
        end
    end

    // Registers without reset.
    always_ff @(posedge clk) begin
        if (w_wen_status)
            r_im <= wdata[ST_IM_LO +: 8];
        if (w_wen_epc)
            r_epc <= wdata;
        if (w_exc && !r_exl)
            r_epc <= ex_epc;
        if (w_exc && is_addr_exc(ex_excode))
            r_badvaddr <= ex_badvaddr;
    end

    always_comb begin
        status             = '0;
        status[ST_BEV]     = r_bev;
        status[ST_IM_LO +: 8] = r_im;
        status[ST_EXL]     = r_exl;
        status[ST_IE]      = r_ie;
    end

    always_comb begin
        cause                    = '0;
        cause[CA_BD]             = r_bd;
        cause[CA_TI]             = w_timer_int;
        cause[CA_IPHW_LO +: 6]   = r_ip_hw;
        cause[CA_IP_LO +: 2]     = r_ip_sw;
        cause[CA_EXC_LO +: 5]    = r_exccode;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_BADVADDR: rdata = r_badvaddr;
            ADDR_COUNT:    rdata = w_count;
            ADDR_COMPARE:  rdata = w_compare;
            ADDR_STATUS:   rdata = status;
            ADDR_CAUSE:    rdata = cause;
            ADDR_EPC:      rdata = r_epc;
            default:       rdata = '0;
        endcase
    end

    assign epc      = r_epc;
    assign int_req  = r_int_req;
    assign ex_entry = r_bev ? VEC_BOOT : VEC_NORMAL;

endmodule
